// File: rtl/layer_compositor.sv
// Multi-layer sprite compositor: frame-latched layer controls, two-stage
// pixel pipeline (hit/address, then priority select) and an animation sequencer.
module layer_compositor #(
  parameter int unsigned NUM_LAYERS  = 4,
  parameter int unsigned ROW_W       = 8,
  parameter int unsigned COL_W       = 8,
  parameter logic [11:0] TRANSPARENT = 12'hF0F,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  parameter int unsigned ANIM_FRAMES = 4,
  parameter int unsigned ANIM_TICKS  = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              bright,
  input  logic [9:0]                        hCount,
  input  logic [9:0]                        vCount,
  input  logic [NUM_LAYERS-1:0]             layer_en,
  input  logic [10*NUM_LAYERS-1:0]          layer_x,
  input  logic [10*NUM_LAYERS-1:0]          layer_y,
  input  logic [10*NUM_LAYERS-1:0]          layer_w,
  input  logic [10*NUM_LAYERS-1:0]          layer_h,
  output logic [ROW_W*NUM_LAYERS-1:0]       rom_row,
  output logic [COL_W*NUM_LAYERS-1:0]       rom_col,
  input  logic [12*NUM_LAYERS-1:0]          rom_data,
  input  logic                              anim_trigger,
  output logic [$clog2((ANIM_FRAMES > 1) ? ANIM_FRAMES : 2)-1:0] anim_frame,
  output logic                              anim_busy,
  output logic [11:0]                       rgb
);

  localparam int unsigned AF_W = $clog2((ANIM_FRAMES > 1) ? ANIM_FRAMES : 2);
  localparam int unsigned TK_W = $clog2((ANIM_TICKS > 1) ? ANIM_TICKS : 2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic                      w_frame_start;
  logic [NUM_LAYERS-1:0]     r_en;
  logic [9:0]                r_x [NUM_LAYERS];
  logic [9:0]                r_y [NUM_LAYERS];
  logic [9:0]                r_w [NUM_LAYERS];
  logic [9:0]                r_h [NUM_LAYERS];

  logic [NUM_LAYERS-1:0]     w_hit;
  logic [ROW_W*NUM_LAYERS-1:0] w_row;
  logic [COL_W*NUM_LAYERS-1:0] w_col;
  logic [NUM_LAYERS-1:0]     r_hit;
  logic                      r_bright;
  logic [11:0]               w_pix;

  state_t                    r_state, w_state_nxt;
  logic [AF_W-1:0]           r_frame, w_frame_nxt;
  logic [TK_W-1:0]           r_tick, w_tick_nxt;
  logic                      r_busy, w_busy_nxt;

  assign w_frame_start = (hCount == 10'd0) && (vCount == 10'd0);

  // Shadow copies of the layer controls, refreshed only at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= '0;
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_w[i] <= '0;
        r_h[i] <= '0;
      end
    end else if (w_frame_start) begin
      r_en <= layer_en;
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        r_x[i] <= layer_x[10*i +: 10];
        r_y[i] <= layer_y[10*i +: 10];
        r_w[i] <= layer_w[10*i +: 10];
        r_h[i] <= layer_h[10*i +: 10];
      end
    end
  end

  // Per-layer rectangle test and ROM address; edges use 11-bit sums so x+w never wraps
  for (genvar gi = 0; gi < int'(NUM_LAYERS); gi++) begin : g_layer
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    assign w_x_end = {1'b0, r_x[gi]} + {1'b0, r_w[gi]};
    assign w_y_end = {1'b0, r_y[gi]} + {1'b0, r_h[gi]};
    assign w_hit[gi] = r_en[gi]
                     && (hCount >= r_x[gi]) && ({1'b0, hCount} < w_x_end)
                     && (vCount >= r_y[gi]) && ({1'b0, vCount} < w_y_end);
    assign w_dx = hCount - r_x[gi];
    assign w_dy = vCount - r_y[gi];
    assign w_row[ROW_W*gi +: ROW_W] = ROW_W'(w_dy);
    assign w_col[COL_W*gi +: COL_W] = COL_W'(w_dx);
  end

  // Stage 0: register hits, visibility and ROM addresses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit    <= '0;
      r_bright <= 1'b0;
      rom_row  <= '0;
      rom_col  <= '0;
    end else begin
      r_hit    <= w_hit;
      r_bright <= bright;
      rom_row  <= w_row;
      rom_col  <= w_col;
    end
  end

  // Stage 1 select: lowest-index opaque hit wins, background otherwise, black off-screen
  always_comb begin
    w_pix = BG_COLOR;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (r_hit[i] && (rom_data[12*i +: 12] != TRANSPARENT)) begin
        w_pix = rom_data[12*i +: 12];
      end
    end
    if (!r_bright) begin
      w_pix = 12'h000;
    end
  end

  // Stage 1 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= 12'h000;
    end else begin
      rgb <= w_pix;
    end
  end

  // Animation sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_frame <= '0;
      r_tick  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_tick  <= w_tick_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Animation next state: hold each frame for ANIM_TICKS frame starts, then return to idle
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_tick_nxt  = r_tick;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (anim_trigger && (ANIM_FRAMES > 1)) begin
          w_state_nxt = S_RUN;
          w_frame_nxt = AF_W'(1);
          w_tick_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (w_frame_start) begin
          if (r_tick == TK_W'(ANIM_TICKS - 1)) begin
            w_tick_nxt = '0;
            if (r_frame == AF_W'(ANIM_FRAMES - 1)) begin
              w_state_nxt = S_IDLE;
              w_frame_nxt = '0;
              w_busy_nxt  = 1'b0;
            end else begin
              w_frame_nxt = r_frame + AF_W'(1);
            end
          end else begin
            w_tick_nxt = r_tick + TK_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign anim_frame = r_frame;
  assign anim_busy  = r_busy;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: pixel-level reference model plus
// frame-count model of the animation sequencer.
module tb_layer_compositor;

  localparam int          N   = 4;
  localparam int          AF  = 4;
  localparam int          AT  = 6;
  localparam logic [11:0] TR  = 12'hF0F;
  localparam logic [11:0] BG  = 12'h5A5;

  logic          clk;
  logic          rst_n;
  logic          bright;
  logic [9:0]    hCount;
  logic [9:0]    vCount;
  logic [N-1:0]  layer_en;
  logic [10*N-1:0] layer_x;
  logic [10*N-1:0] layer_y;
  logic [10*N-1:0] layer_w;
  logic [10*N-1:0] layer_h;
  logic [8*N-1:0]  rom_row;
  logic [8*N-1:0]  rom_col;
  logic [12*N-1:0] rom_data;
  logic          anim_trigger;
  logic [1:0]    anim_frame;
  logic          anim_busy;
  logic [11:0]   rgb;

  layer_compositor #(
    .NUM_LAYERS(N), .ROW_W(8), .COL_W(8), .TRANSPARENT(TR), .BG_COLOR(BG),
    .ANIM_FRAMES(AF), .ANIM_TICKS(AT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bright(bright), .hCount(hCount), .vCount(vCount),
    .layer_en(layer_en), .layer_x(layer_x), .layer_y(layer_y), .layer_w(layer_w),
    .layer_h(layer_h), .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .anim_trigger(anim_trigger), .anim_frame(anim_frame), .anim_busy(anim_busy),
    .rgb(rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ROM contents: either a constant per layer or a seeded pattern with transparent holes
  int          seed = 0;
  bit          rom_mode = 1'b0;
  logic [11:0] rom_const [N];

  function automatic logic [11:0] rom_fn(int i, int r, int c, int sd, bit mode, logic [11:0] cst);
    if (mode) return cst;
    if (((r + c + i + sd) % 5) == 0) return 12'hF0F;
    return 12'(r * 37 + c * 11 + i * 101 + sd);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom_data[12*g +: 12] = rom_fn(g, int'(rom_row[8*g +: 8]), int'(rom_col[8*g +: 8]),
                                         seed, rom_mode, rom_const[g]);
  end

  // Reference model state
  bit m_en [N];
  int m_x [N];
  int m_y [N];
  int m_w [N];
  int m_h [N];
  bit m_busy = 1'b0;
  int m_fscnt = 0;

  logic [11:0] exp_q [$];
  int          pix_q [$];
  bit          vld = 1'b0;
  bit          v1 = 1'b0;
  bit          v2 = 1'b0;
  bit          mon_on = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(int h, int v, bit b);
    logic [11:0] d;
    if (!b) return 12'h000;
    for (int i = 0; i < N; i++) begin
      if (m_en[i] && h >= m_x[i] && h < m_x[i] + m_w[i] && v >= m_y[i] && v < m_y[i] + m_h[i]) begin
        d = rom_fn(i, (v - m_y[i]) % 256, (h - m_x[i]) % 256, seed, rom_mode, rom_const[i]);
        if (d != TR) return d;
      end
    end
    return BG;
  endfunction

  // One pixel clock: advance the model over the edge just taken, then present new inputs
  task automatic drive(int h, int v, bit b, bit chk, bit trg);
    bit fs;
    @(posedge clk);
    if (rst_n) begin
      fs = (hCount == 10'd0) && (vCount == 10'd0);
      if (!m_busy && anim_trigger && AF > 1) begin
        m_busy  = 1'b1;
        m_fscnt = 0;
      end else if (m_busy && fs) begin
        m_fscnt++;
        if (m_fscnt == (AF - 1) * AT) m_busy = 1'b0;
      end
      if (fs) begin
        for (int i = 0; i < N; i++) begin
          m_en[i] = layer_en[i];
          m_x[i]  = int'(layer_x[10*i +: 10]);
          m_y[i]  = int'(layer_y[10*i +: 10]);
          m_w[i]  = int'(layer_w[10*i +: 10]);
          m_h[i]  = int'(layer_h[10*i +: 10]);
        end
      end
    end
    #1;
    hCount       = 10'(h);
    vCount       = 10'(v);
    bright       = b;
    anim_trigger = trg;
    vld          = chk;
    if (chk) begin
      exp_q.push_back(exp_pix(h, v, b));
      pix_q.push_back(h * 1024 + v);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) drive(7, 7, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame_start();
    drive(0, 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic set_layer(int i, int x, int y, int w, int h);
    layer_x[10*i +: 10] = 10'(x);
    layer_y[10*i +: 10] = 10'(y);
    layer_w[10*i +: 10] = 10'(w);
    layer_h[10*i +: 10] = 10'(h);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0;
    end
    m_busy  = 1'b0;
    m_fscnt = 0;
  endtask

  // Pipeline tag following each checked pixel to the rgb output
  always @(posedge clk) begin
    v1 <= vld;
    v2 <= v1;
  end

  // Monitor: compare rgb against the scoreboard and the animation outputs against the model
  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      if (v2) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          logic [11:0] e;
          int p;
          e = exp_q.pop_front();
          p = pix_q.pop_front();
          check($sformatf("rgb(%0d,%0d)", p / 1024, p % 1024), 32'(rgb), 32'(e));
        end
      end
      check("anim_frame", 32'(anim_frame), m_busy ? 32'(1 + m_fscnt / AT) : 32'd0);
      check("anim_busy", 32'(anim_busy), 32'(m_busy));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int busy_fs;
    rst_n = 1'b0; bright = 1'b0; hCount = 10'd5; vCount = 10'd5;
    layer_en = '0; layer_x = '0; layer_y = '0; layer_w = '0; layer_h = '0;
    anim_trigger = 1'b0;
    for (int i = 0; i < N; i++) rom_const[i] = 12'h000;
    clear_model();
    repeat (3) @(posedge clk);
    #2;
    check("reset_rgb", 32'(rgb), 32'h0);
    check("reset_rom_row", rom_row, 32'h0);
    check("reset_rom_col", rom_col, 32'h0);
    check("reset_anim_frame", 32'(anim_frame), 32'h0);
    check("reset_anim_busy", 32'(anim_busy), 32'h0);
    rst_n = 1'b1;
    mon_on = 1'b1;

    // Single opaque layer 1
    rom_mode = 1'b1; rom_const[1] = 12'h0F0;
    layer_en = 4'b0010; set_layer(1, 300, 200, 4, 2);
    frame_start();
    for (int v = 199; v <= 202; v++)
      for (int h = 298; h <= 305; h++) drive(h, v, 1'b1, 1'b1, 1'b0);
    for (int h = 300; h <= 303; h++) drive(h, 200, 1'b0, 1'b1, 1'b0);
    drain();

    // Priority between overlapping layers 0 and 2, then layer 0 transparent
    rom_const[0] = 12'hF00; rom_const[2] = 12'h00F;
    layer_en = 4'b0101; set_layer(0, 300, 200, 8, 4); set_layer(2, 304, 202, 8, 4);
    frame_start();
    for (int v = 201; v <= 206; v++)
      for (int h = 302; h <= 313; h++) drive(h, v, 1'b1, 1'b1, 1'b0);
    drain();
    rom_const[0] = TR;
    for (int h = 302; h <= 313; h++) drive(h, 203, 1'b1, 1'b1, 1'b0);
    drain();

    // Mid-frame position change only takes effect at the next frame start
    rom_const[1] = 12'h0F0;
    layer_en = 4'b0010; set_layer(1, 300, 200, 4, 100);
    frame_start();
    for (int h = 298; h <= 315; h++) drive(h, 249, 1'b1, 1'b1, 1'b0);
    drive(298, 250, 1'b1, 1'b1, 1'b0);
    layer_x[10 +: 10] = 10'd310;
    for (int v = 250; v <= 252; v++)
      for (int h = 298; h <= 315; h++) drive(h, v, 1'b1, 1'b1, 1'b0);
    frame_start();
    for (int h = 298; h <= 315; h++) drive(h, 250, 1'b1, 1'b1, 1'b0);
    drain();

    // Zero-width layer never drawn; right-edge layer clipped without wrap
    rom_mode = 1'b0; seed = 3;
    layer_en = 4'b1001; set_layer(0, 1018, 10, 0, 5); set_layer(3, 1020, 10, 10, 3);
    frame_start();
    for (int v = 9; v <= 13; v++) begin
      for (int h = 1014; h <= 1023; h++) drive(h, v, 1'b1, 1'b1, 1'b0);
      for (int h = 1; h <= 5; h++) drive(h, v, 1'b1, 1'b1, 1'b0);
    end
    drain();

    // Animation: one run, a retrigger mid-run and a trigger on the final frame start
    drive(5, 5, 1'b1, 1'b1, 1'b1);
    busy_fs = 0;
    for (int f = 0; f < 22; f++) begin
      drive(0, 0, 1'b1, 1'b1, f == 17);
      if (anim_busy) busy_fs++;
      drive(3, 3, 1'b1, 1'b1, f == 8);
      drive(4, 4, 1'b1, 1'b1, 1'b0);
    end
    check("busy_frame_starts", 32'(busy_fs), 32'd18);
    drain();

    // Asynchronous reset while running and mid-frame
    rom_mode = 1'b1; rom_const[1] = 12'h0F0;
    layer_en = 4'b0010; set_layer(1, 300, 200, 4, 2);
    frame_start();
    drive(5, 5, 1'b1, 1'b1, 1'b1);
    frame_start();
    drive(301, 200, 1'b1, 1'b1, 1'b0);
    drive(302, 201, 1'b1, 1'b1, 1'b0);
    drain();
    mon_on = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rgb", 32'(rgb), 32'h0);
    check("async_rst_anim_frame", 32'(anim_frame), 32'h0);
    check("async_rst_anim_busy", 32'(anim_busy), 32'h0);
    check("async_rst_rom_row", rom_row, 32'h0);
    clear_model();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mon_on = 1'b1;
    drive(301, 200, 1'b1, 1'b1, 1'b0);
    drive(302, 201, 1'b1, 1'b1, 1'b0);
    frame_start();
    drive(301, 200, 1'b1, 1'b1, 1'b0);
    drive(302, 201, 1'b0, 1'b1, 1'b0);
    drain();

    // Randomized frames with mid-frame control churn
    rom_mode = 1'b0;
    for (int fr = 0; fr < 25; fr++) begin
      drain();
      seed = int'($urandom_range(0, 999));
      layer_en = 4'($urandom);
      for (int i = 0; i < N; i++)
        set_layer(i, $urandom_range(0, 80), $urandom_range(0, 80),
                  $urandom_range(0, 25), $urandom_range(0, 25));
      frame_start();
      for (int k = 0; k < 100; k++) begin
        if (k == 50) begin
          layer_en = 4'($urandom);
          set_layer(int'($urandom_range(0, N - 1)), $urandom_range(0, 80),
                    $urandom_range(0, 80), $urandom_range(0, 25), $urandom_range(0, 25));
        end
        drive($urandom_range(0, 100), $urandom_range(0, 100), ($urandom % 8) != 0,
              1'b1, ($urandom % 50) == 0);
      end
    end
    drain();
    drain();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised successor to the single-layer render mux.
- Composites NUM_LAYERS rectangular sprite layers (title, gun, enemy, background, ...) over a fixed background colour. Uses per-layer screen position, per-layer size, a fixed priority order and a transparency colour key.
- Sits between the VGA timing generator and the external sprite ROMs. Drives one ROM address per layer and receives the ROM data one cycle later. Produces a pipelined 12-bit rgb output.
- Adds three things the old mux did not have:
  - frame-synchronous latching of layer controls, so there is no tearing;
  - a built-in gun/sprite animation sequencer;
  - pixel-pipeline alignment.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has the highest priority.
- ROW_W, 8, width of the per-layer ROM row address.
- COL_W, 8, width of the per-layer ROM column address.
- TRANSPARENT, 12'hF0F, ROM colour treated as see-through.
- BG_COLOR, 12'h000, colour shown where no layer is opaque.
- ANIM_FRAMES, 4, number of animation frames, including idle frame 0.
- ANIM_TICKS, 6, video frames each animation frame is held.

Ports:
- clk  in  1  pixel clock; one hCount step per cycle.
- rst_n  in  1  asynchronous active-low reset.
- bright  in  1  visible-area flag from the timing generator.
- hCount  in  10  current pixel column.
- vCount  in  10  current pixel row.
- layer_en  in  NUM_LAYERS  per-layer enable.
- layer_x  in  10*NUM_LAYERS  left edge of each layer (packed; layer i at [10i+9:10i]).
- layer_y  in  10*NUM_LAYERS  top edge of each layer.
- layer_w  in  10*NUM_LAYERS  width of each layer in pixels.
- layer_h  in  10*NUM_LAYERS  height of each layer in pixels.
- rom_row  out  ROW_W*NUM_LAYERS  ROM row address per layer.
- rom_col  out  COL_W*NUM_LAYERS  ROM column address per layer.
- rom_data  in  12*NUM_LAYERS  ROM pixel per layer; valid exactly 1 cycle after the address.
- anim_trigger  in  1  single-cycle request to start the animation.
- anim_frame  out  clog2(ANIM_FRAMES)  current animation frame, used by the top level to select ROMs.
- anim_busy  out  1  high while the animation sequence runs.
- rgb  out  12  composited pixel.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rgb = 0, rom_row = 0, rom_col = 0, anim_frame = 0, anim_busy = 0;
  - all latched layer registers = 0 (all layers disabled);
  - all pipeline registers = 0.
- Frame start: the cycle where hCount==0 and vCount==0.
- Control latch:
  - On the frame-start cycle, layer_en, layer_x, layer_y, layer_w and layer_h are copied into shadow registers.
  - All compositing uses only the shadow copies. Mid-frame changes to the inputs have no effect until the next frame start.
- Stage 0 (registered at the end of cycle n, per layer i):
  - hit_i = en_i && hCount>=x_i && hCount<x_i+w_i && vCount>=y_i && vCount<y_i+h_i.
  - The additions are computed 11 bits wide, so there is no wrap.
  - w_i=0 or h_i=0 means never hit.
  - rom_row_i = (vCount-y_i) truncated to ROW_W; rom_col_i = (hCount-x_i) truncated to COL_W.
  - Addresses are driven even when not hit; don't-care values are fine there.
  - bright is delayed along with hit.
- Stage 1 (cycle n+1, registered into rgb): select the lowest index i with hit_i && rom_data_i != TRANSPARENT and output its rom_data.
  - If no layer qualifies, output BG_COLOR.
  - If the delayed bright is 0, output 12'h000.
- Latency: rgb for pixel (hCount, vCount) at cycle n appears on the output at cycle n+2. The top level delays hsync/vsync by 2 to match.
- Animation sequencer, states:
  - IDLE: anim_frame=0, anim_busy=0. On anim_trigger, go to RUN with anim_frame=1 and tick counter=0.
  - RUN: the tick counter increments at each frame start. When counter==ANIM_TICKS-1 at a frame start, the counter goes to 0 and anim_frame increments.
  - Leaving RUN: when anim_frame==ANIM_FRAMES-1 and the counter wraps, go to IDLE with anim_frame=0.
  - anim_busy=1 throughout RUN.
- Boundary cases:
  - anim_trigger while in RUN is ignored; there is no restart and no queueing.
  - anim_trigger on the same cycle as the return to IDLE is ignored.
  - ANIM_FRAMES=1 means a trigger has no effect.
- A layer whose right edge (x+w) reaches 1024 is clipped by hCount range only; there is no wrap into column 0.
- Reset mid-frame: the shadow registers clear, so all layers are disabled and rgb shows BG_COLOR (or black when not bright) until the next frame start latches the inputs.

Test Plan:
1. Only layer 1 enabled, at x=300 y=200 w=4 h=2, ROM data 12'h0F0 everywhere. Expected: rgb=0F0 for pixels (300..303, 200..201) two cycles after the pixel; BG_COLOR at pixel (304,200); black while bright=0.
2. Layers 0 and 2 overlap and both are opaque (0:12'hF00, 2:12'h00F) → F00. Layer 0 returns TRANSPARENT → 00F.
3. Change layer_x from 300 to 310 at mid-frame (vCount=250). Expected: the remaining rows of that frame still render at 300; the next frame renders at 310.
4. anim_trigger pulse, ANIM_TICKS=6, ANIM_FRAMES=4. Expected: anim_frame goes 1,2,3 for 6 frame starts each, then 0; anim_busy is high across exactly 18 frame starts. A second trigger during frame 2 changes nothing.
5. Assert rst_n low while in RUN and mid-frame. Expected: anim_frame=0, anim_busy=0 and rgb=0 immediately (asynchronously); layers stay disabled until the next frame start.
6. Layer with w=0 → never drawn. Layer at x=1020 w=10 → drawn only at columns 1020..1023, no wrap.
